// File: rtl/sda_frame_rx.sv
// sda_frame_rx: receive side of the scl/sda serial link.
// Decodes START, NBITS data bits (MSB first, sampled on scl rise), STOP.
// Any number of scl pulses between the last data bit and STOP is ignored.
//
// Ports:
//   sclk     system clock, rising edge
//   rst      asynchronous active-low reset
//   scl,sda  serial clock / data from the transmitter (same clock domain)
//   data     last good frame, MSB = first received bit
//   onehot   onehot[data] = 1; all zero until the first good frame
//   valid    one-cycle pulse when data/onehot update
//   frm_err  one-cycle pulse on a truncated or restarted frame
//   busy     high while a frame is in progress
module sda_frame_rx #(
    parameter int NBITS = 4      // must be >= 2
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic                  scl,
    input  logic                  sda,
    output logic [NBITS-1:0]      data,
    output logic [2**NBITS-1:0]   onehot,
    output logic                  valid,
    output logic                  frm_err,
    output logic                  busy
);
    localparam int OHW = 2**NBITS;
    localparam logic [NBITS-1:0] LAST = NBITS'(NBITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_STOP} state_t;

    state_t           state;
    logic             scl_q, scl_p, sda_q, sda_p;
    logic [NBITS-1:0] shift;
    logic [NBITS-1:0] cnt;
    logic             start_ev, stop_ev, rise_ev;

    // Edge/condition detection on the two sample stages. START and STOP
    // need scl high in both samples, so they can never coincide with a rise.
    assign start_ev = scl_p & scl_q &  sda_p & ~sda_q;
    assign stop_ev  = scl_p & scl_q & ~sda_p &  sda_q;
    assign rise_ev  = ~scl_p & scl_q;

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            // scl=1/sda=0 matches the idle bus seen at transmitter reset,
            // so reset release cannot look like a START.
            scl_q   <= 1'b1;
            scl_p   <= 1'b1;
            sda_q   <= 1'b0;
            sda_p   <= 1'b0;
            state   <= IDLE;
            shift   <= '0;
            cnt     <= '0;
            data    <= '0;
            onehot  <= '0;
            valid   <= 1'b0;
            frm_err <= 1'b0;
            busy    <= 1'b0;
        end else begin
            scl_q   <= scl;
            scl_p   <= scl_q;
            sda_q   <= sda;
            sda_p   <= sda_q;
            valid   <= 1'b0;
            frm_err <= 1'b0;
            case (state)
                IDLE: begin
                    // STOP here is the transmitter leaving its ready state.
                    if (start_ev) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (start_ev) begin
                        frm_err <= 1'b1;
                        cnt     <= '0;
                        busy    <= 1'b1;
                    end else if (stop_ev) begin
                        frm_err <= 1'b1;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        busy <= 1'b1;
                        if (rise_ev) begin
                            shift <= {shift[NBITS-2:0], sda_q};
                            cnt   <= cnt + 1'b1;
                            if (cnt == LAST)
                                state <= WAIT_STOP;
                        end
                    end
                end
                WAIT_STOP: begin
                    // Trailing scl pulses are tolerated until STOP.
                    if (start_ev) begin
                        frm_err <= 1'b1;
                        state   <= SHIFT;
                        cnt     <= '0;
                        busy    <= 1'b1;
                    end else if (stop_ev) begin
                        data   <= shift;
                        onehot <= OHW'(1) << shift;
                        valid  <= 1'b1;
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end else begin
                        busy <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
